// File: rtl/seg7_scan_pkg.sv
// Shared constants and state encoding for the seven-segment scan driver.
package seg7_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic       AN_OFF    = 1'b1;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7.sv
// Hex-to-seven-segment decoder, active-low segments a..g with a in the MSB.
module seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Combinational glyph lookup
  always_comb begin
    case (hex)
      4'h0:    seg = 7'b000_0001;
      4'h1:    seg = 7'b100_1111;
      4'h2:    seg = 7'b001_0010;
      4'h3:    seg = 7'b000_0110;
      4'h4:    seg = 7'b100_1100;
      4'h5:    seg = 7'b010_0100;
      4'h6:    seg = 7'b010_0000;
      4'h7:    seg = 7'b000_1111;
      4'h8:    seg = 7'b000_0000;
      4'h9:    seg = 7'b000_0100;
      4'hA:    seg = 7'b000_1000;
      4'hB:    seg = 7'b110_0000;
      4'hC:    seg = 7'b011_0001;
      4'hD:    seg = 7'b100_0010;
      4'hE:    seg = 7'b011_0000;
      4'hF:    seg = 7'b011_1000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode display driver with frame-aligned
// updates, leading-zero blanking and per-slot anti-ghosting blank cycles.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int VW = 4 * DIGITS;
  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST       = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOT_BLANK_LAST = SW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST        = IW'(DIGITS - 1);
  localparam scan_state_e   ST_RESET        = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

  logic [SW-1:0]     slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  scan_state_e       state_q, state_d;
  logic              pend_q, pend_d;
  logic [VW-1:0]     pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VW-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              slot_wrap;
  logic              frame_end;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              lz_blank;
  logic [6:0]        dec_seg;

  assign slot_wrap = (slot_cnt_q == SLOT_LAST);
  assign frame_end = slot_wrap && (idx_q == IDX_LAST);

  // Slot/digit counters and the pending -> display hand-off
  always_comb begin
    if (slot_wrap) begin
      slot_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
      idx_d      = idx_q;
    end

    // Commit consumes the old pending data even if a load lands on the same edge.
    if (frame_end && pend_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
    end else begin
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
    end

    if (load) begin
      pend_d     = 1'b1;
      pend_val_d = value;
      pend_dp_d  = dp_mask;
    end else if (frame_end) begin
      pend_d     = 1'b0;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
    end else begin
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
    end
  end

  // Select the current digit and decide whether it is a leading zero
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    lz_blank = blank_lz && (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      cur_nib  = (idx_q == IW'(i)) ? disp_val_q[4*i +: 4] : cur_nib;
      cur_dp   = (idx_q == IW'(i)) ? disp_dp_q[i] : cur_dp;
      lz_blank = lz_blank & ~((IW'(i) >= idx_q) & (disp_val_q[4*i +: 4] != 4'h0));
    end
  end

  seg7 u_seg7 (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: blank window at the start of every slot
  always_comb begin
    case (state_q)
      ST_BLANK: begin
        if (slot_cnt_q == SLOT_BLANK_LAST) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (slot_wrap && (BLANK_CYC > 0)) begin
          state_d = ST_BLANK;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // FSM outputs, registered below so an/seg/dp move on the same edge
  always_comb begin
    an_d  = {DIGITS{AN_OFF}};
    seg_d = dec_seg;
    dp_d  = ~cur_dp;
    if ((state_q == ST_DRIVE) && !lz_blank) begin
      an_d[idx_q] = 1'b0;
    end else begin
      an_d = {DIGITS{AN_OFF}};
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= {DIGITS{AN_OFF}};
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan against a cycle-count based display model.
module tb_seg7_scan;

  localparam int DIGITS = 8;
  localparam int RD     = 4;
  localparam int BC     = 1;
  localparam int FRAME  = DIGITS * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
    7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
    7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
    7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
  };

  // Reference model: position derives from cycles since reset
  int          m_cyc;
  logic        m_pend;
  logic [31:0] m_pval, m_dval, m_shown;
  logic [7:0]  m_pdp, m_ddp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    int          slot;
    int          dig;
    logic [31:0] upper;
    @(posedge clk);
    if (rst) begin
      m_cyc  = 0;
      m_pend = 1'b0;
      m_pval = 32'h0;
      m_pdp  = 8'h0;
      m_dval = 32'h0;
      m_ddp  = 8'h0;
      m_shown = 32'h0;
      exp_an = 8'hFF;
      exp_seg = 7'b111_1111;
      exp_dp = 1'b1;
    end else begin
      slot  = m_cyc % RD;
      dig   = (m_cyc / RD) % DIGITS;
      upper = m_dval >> (4 * dig);
      m_shown = m_dval;
      exp_an = 8'hFF;
      if (slot >= BC && !(blank_lz && dig > 0 && upper == 32'h0))
        exp_an[dig] = 1'b0;
      exp_seg = seg_tab[upper[3:0]];
      exp_dp  = ~m_ddp[dig];
      if (slot == RD - 1 && dig == DIGITS - 1 && m_pend) begin
        m_dval = m_pval;
        m_ddp  = m_pdp;
        m_pend = 1'b0;
      end
      if (load) begin
        m_pend = 1'b1;
        m_pval = value;
        m_pdp  = dp_mask;
      end
      m_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic goto(input int dig, input int slot);
    int guard = 0;
    while (!((m_cyc % RD) == slot && ((m_cyc / RD) % DIGITS) == dig) && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    if (guard >= 4 * FRAME) begin
      n_fail++;
      $display("FAIL goto_timeout dig=%0d slot=%0d not reached", dig, slot);
    end
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] m);
    value   = v;
    dp_mask = m;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value = 32'h0; dp_mask = 8'h0;
    repeat (3) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {8'hFF, 7'b111_1111, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_hold got an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1", an, seg, dp);
      end
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (an !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_first_blank got an=%h want ff", an);
    end
    step();
    n_checks++;
    if ({an, seg, dp} !== {8'hFE, 7'b000_0001, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_anode got an=%h seg=%b dp=%b want an=fe seg=0000001 dp=1", an, seg, dp);
    end
    repeat (FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL reset_idle got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_full_scan();
    int blanks = 0;
    pulse_load(32'h12345678, 8'h00);
    repeat (3 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL full_scan got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (m_shown == 32'h12345678) begin
        if (an == 8'hFF) blanks++;
        if (an == 8'hFE || an == 8'hFD || an == 8'h7F) begin
          n_checks++;
          if (seg !== ((an == 8'hFE) ? 7'b000_0000 : (an == 8'hFD) ? 7'b000_1111 : 7'b100_1111)) begin
            n_fail++;
            $display("FAIL full_scan_glyph an=%h got seg=%b", an, seg);
          end
        end
      end
    end
    n_checks++;
    if (blanks < DIGITS) begin
      n_fail++;
      $display("FAIL full_scan_blank_slots got %0d want >= %0d", blanks, DIGITS);
    end
  endtask

  task automatic test_lz();
    blank_lz = 1'b1;
    pulse_load(32'h00000A05, 8'h00);
    repeat (3 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL lz_a05 got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (m_shown == 32'h00000A05) begin
        n_checks++;
        if (an[7:3] !== 5'b11111) begin
          n_fail++;
          $display("FAIL lz_a05_high got an=%h want an[7:3]=11111", an);
        end
      end
    end
    pulse_load(32'h0, 8'h00);
    repeat (3 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL lz_zero got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (m_shown == 32'h0 && an != 8'hFF) begin
        n_checks++;
        if ({an, seg} !== {8'hFE, 7'b000_0001}) begin
          n_fail++;
          $display("FAIL lz_zero_digit0 got an=%h seg=%b want an=fe seg=0000001", an, seg);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_midframe();
    int guard = 0;
    pulse_load(32'h22222222, 8'h00);
    while (m_dval != 32'h22222222 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    goto(3, 1);
    pulse_load(32'h11111111, 8'h00);
    repeat (2 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL midframe got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    n_checks++;
    if (m_dval !== 32'h11111111 || seg !== 7'b100_1111) begin
      n_fail++;
      $display("FAIL midframe_committed got seg=%b want 1001111", seg);
    end
    goto(1, 2);
    pulse_load(32'h33333333, 8'h00);
    goto(5, 2);
    pulse_load(32'h44444444, 8'h00);
    repeat (2 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp} || (an != 8'hFF && seg == 7'b000_0110)) begin
        n_fail++;
        $display("FAIL two_loads got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_boundary_load();
    goto(6, 0);
    pulse_load(32'h55555555, 8'h00);
    goto(7, 3);
    pulse_load(32'h66666666, 8'h00);
    repeat (2 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL boundary_load got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_dp();
    pulse_load(32'h87654321, 8'b0000_0100);
    repeat (3 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL dp got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (m_shown == 32'h87654321 && an != 8'hFF) begin
        n_checks++;
        if (dp !== (an != 8'hFB)) begin
          n_fail++;
          $display("FAIL dp_digit2 an=%h got dp=%b", an, dp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    goto(5, 1);
    pulse_load(32'h77777777, 8'hFF);
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({an, seg, dp} !== {8'hFF, 7'b111_1111, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid got an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1", an, seg, dp);
    end
    rst = 1'b0;
    repeat (3 * FRAME) begin
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp} || (an != 8'hFF && seg !== 7'b000_0001)) begin
        n_fail++;
        $display("FAIL reset_mid_after got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    repeat (12 * FRAME) begin
      load    = ($urandom_range(0, 11) == 0);
      value   = $urandom >> (4 * $urandom_range(0, 7));
      dp_mask = 8'($urandom);
      if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
      step();
      n_checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL random got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_lz();
    test_midframe();
    test_boundary_load();
    test_dp();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
